cv32e40s_dbg_trace_buf: RTL and testbench
=========================================

# cv32e40s_dbg_trace_buf

Debug-only instruction history buffer fed by the ID stage alongside the decode debug-helper signals. Every accepted ID-stage instruction's decode record is written into a DEPTH-entry circular buffer. An illegal instruction can freeze the buffer after a programmable post-trigger window, preserving the history around the fault. A registered read port exposes entries by age for testbench or waveform inspection.

## Interface
- DEPTH, 8, number of entries; power of two, at least 2
- REGFILE_NUM_READ_PORTS, 2, register file read ports recorded per entry
- POST_TRIG, 2, entries captured after the trigger entry before freezing; 0 to DEPTH-1
- clk  in  1  clock
- rst  in  1  reset; **asynchronous, active-high**, single clock domain (clk)
- capture_valid_i  in  1  ID-stage instruction accepted this cycle
- instr_i  in  32  instruction word
- is_compressed_i  in  1  compressed instruction
- rf_re_i  in  REGFILE_NUM_READ_PORTS  register file read enables
- rf_raddr_i  in  rf_addr_t[REGFILE_NUM_READ_PORTS]  read addresses (unpacked array)
- rf_we_i  in  1  register file write enable
- rf_waddr_i  in  rf_addr_t  write address
- illegal_insn_i  in  1  illegal instruction; trigger source
- freeze_clr_i  in  1  leave FROZEN and restart capture
- rd_req_i  in  1  read request
- rd_idx_i  in  $clog2(DEPTH)  age index; 0 is the newest entry
- rd_valid_o  out  1  read response strobe
- rd_err_o  out  1  requested index is at or above count
- rd_entry_o  out  dbg_trace_entry_t  read data
- count_o  out  $clog2(DEPTH)+1  valid entries, saturating at DEPTH
- frozen_o  out  1  buffer frozen

## Operation
- State machine trace_state_e has three states: RUN, POST, FROZEN. Reset state is RUN.
- Capture happens when capture_valid_i is high and the state is RUN or POST.
  - The entry is written at wr_ptr, then wr_ptr increments modulo DEPTH.
  - count increments and saturates at DEPTH. On wrap, the oldest entry is overwritten.
- RUN transitions:
  - A capture with illegal_insn_i high records the entry, including its illegal flag.
  - It then goes to FROZEN if POST_TRIG is 0. Otherwise it loads post_cnt with POST_TRIG and goes to POST.
- POST: each capture decrements post_cnt. The capture that takes post_cnt to 0 moves the state to FROZEN. illegal_insn_i in POST does not retrigger.
- FROZEN: captures are dropped. freeze_clr_i moves the state to RUN and clears count to 0; wr_ptr is unchanged.
- Read: the physical slot is (wr_ptr - 1 - rd_idx_i) mod DEPTH, computed with the pre-update wr_ptr. Reads are allowed in every state.
- rd_idx_i >= count: rd_err_o is 1 and rd_entry_o is all zeros.

## Timing
- Reset value of every output is 0: rd_valid_o, rd_err_o, rd_entry_o, count_o and frozen_o.
- Reset also clears wr_ptr, post_cnt and the storage. Reset mid-POST returns to RUN with no freeze.
- Capture is visible to a read requested one cycle later. count_o and frozen_o update at the capturing edge.
- Read latency is 1 cycle: a request on edge N gives rd_valid_o high for exactly one cycle after N, with data and error. There is no backpressure, so back-to-back requests each respond.
- A capture and a read in the same cycle: the read returns pre-capture contents and indexing.
- freeze_clr_i together with capture_valid_i in FROZEN: the clear wins and that capture is dropped.
- A trigger at count equal to DEPTH still freezes correctly; overwrite continues during POST.

## Configuration
- CV32E40S_DBG_TRACE_FREEZE_EN defined: trigger, POST and FROZEN behave as described above.
- CV32E40S_DBG_TRACE_FREEZE_EN undefined:
  - the state is permanently RUN and illegal_insn_i is only recorded;
  - freeze_clr_i is ignored and frozen_o is tied to 0;
  - the post_cnt logic is removed.

## Structure
- cv32e40s_pkg contains:
  - dbg_trace_entry_t: a packed struct of instr, is_compressed, rf_re, rf_raddr, rf_we, rf_waddr and illegal_insn;
  - trace_state_e;
  - the RF_ADDR_WIDTH constant, which already exists.
- rf_raddr_i is converted from unpacked to packed with a generate loop.
- Sub-module cv32e40s_dbg_trace_mem holds the flop array: one write port and one registered read port with a read-data-valid output.

## Test plan
- Capture 3 instructions (0x00000013, 0x00100093, 0x00208113), then read indices 0, 1, 2 and 3:
  - indices 0 to 2 return the instructions newest first: 0x00208113, 0x00100093, 0x00000013;
  - index 3 returns rd_err_o high with a zero entry;
  - count_o is 3.
- Capture 11 instructions with DEPTH=8: count_o is 8, index 7 returns instruction #4, and index 0 returns #11.
- With POST_TRIG=2, capture illegal 0x00000000 and then 4 more instructions:
  - frozen_o rises after the 2nd post-trigger capture, and the last 2 are dropped;
  - index 2 returns 0x00000000 with the illegal flag set.
- In FROZEN, assert freeze_clr_i together with capture_valid_i: count_o becomes 0, the capture is dropped, and the next capture gives count_o of 1.
- Read index 0 in the same cycle as a capture: the response is the previous newest entry. On the next cycle, index 0 returns the new entry.
- Assert rst mid-POST: all outputs become 0 immediately and the state is RUN. With the macro undefined, an illegal instruction never raises frozen_o.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
`default_nettype none
// ============================================================================
// cv32e40s_pkg : shared types for the debug trace buffer (entry record, state)
// Revision 1.0
// ============================================================================
package cv32e40s_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

   // Must equal REGFILE_NUM_READ_PORTS of every trace buffer instance.
   localparam int DBG_TRACE_RF_PORTS = 2;

   typedef struct packed {
      logic [31:0]                        instr;
      logic                               is_compressed;
      logic [DBG_TRACE_RF_PORTS-1:0]      rf_re;
      rf_addr_t [DBG_TRACE_RF_PORTS-1:0]  rf_raddr;
      logic                               rf_we;
      rf_addr_t                           rf_waddr;
      logic                               illegal_insn;
   } dbg_trace_entry_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      POST   = 2'd1,
      FROZEN = 2'd2
   } trace_state_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40s_dbg_trace_mem.sv
`default_nettype none
// ============================================================================
// cv32e40s_dbg_trace_mem : trace entry flop array, one write port and one
// registered read port with valid/error strobes.  Revision 1.0
// ============================================================================
module cv32e40s_dbg_trace_mem
   import cv32e40s_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  dbg_trace_entry_t      wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  rzero,
   output logic                  rvalid,
   output logic                  rerr,
   output dbg_trace_entry_t      rdata
);

   dbg_trace_entry_t mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read samples the array before this edge's write lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid <= 1'b0;
         rerr   <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= re;
         rerr   <= re & rzero;
         if (re) begin
            rdata <= rzero ? '0 : mem_q[raddr];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cv32e40s_dbg_trace_buf.sv
`default_nettype none
// ============================================================================
// cv32e40s_dbg_trace_buf : ID-stage decode history buffer with optional freeze
// on illegal instruction (macro CV32E40S_DBG_TRACE_FREEZE_EN).  Revision 1.0
// ============================================================================
module cv32e40s_dbg_trace_buf
   import cv32e40s_pkg::*;
#(
   parameter int DEPTH                  = 8,
   parameter int REGFILE_NUM_READ_PORTS = 2,
   parameter int POST_TRIG              = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              capture_valid_i,
   input  logic [31:0]                       instr_i,
   input  logic                              is_compressed_i,
   input  logic [REGFILE_NUM_READ_PORTS-1:0] rf_re_i,
   input  rf_addr_t                          rf_raddr_i [REGFILE_NUM_READ_PORTS],
   input  logic                              rf_we_i,
   input  rf_addr_t                          rf_waddr_i,
   input  logic                              illegal_insn_i,
   input  logic                              freeze_clr_i,
   input  logic                              rd_req_i,
   input  logic [$clog2(DEPTH)-1:0]          rd_idx_i,
   output logic                              rd_valid_o,
   output logic                              rd_err_o,
   output dbg_trace_entry_t                  rd_entry_o,
   output logic [$clog2(DEPTH):0]            count_o,
   output logic                              frozen_o
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]                            wr_ptr;
   logic [AW:0]                              count;
   logic                                     capture_en;
   logic                                     clear_en;
   rf_addr_t [REGFILE_NUM_READ_PORTS-1:0]    raddr_packed;
   dbg_trace_entry_t                         wr_entry;
   logic [AW-1:0]                            rd_slot;
   logic                                     rd_oob;

   for (genvar g = 0; g < REGFILE_NUM_READ_PORTS; g++) begin : g_raddr_pack
      assign raddr_packed[g] = rf_raddr_i[g];
   end

   always_comb begin
      wr_entry               = '0;
      wr_entry.instr         = instr_i;
      wr_entry.is_compressed = is_compressed_i;
      wr_entry.rf_re         = rf_re_i;
      wr_entry.rf_raddr      = raddr_packed;
      wr_entry.rf_we         = rf_we_i;
      wr_entry.rf_waddr      = rf_waddr_i;
      wr_entry.illegal_insn  = illegal_insn_i;
   end

`ifdef CV32E40S_DBG_TRACE_FREEZE_EN
   localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);

   trace_state_e  state;
   trace_state_e  state_next;
   logic [AW-1:0] post_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (capture_valid_i && illegal_insn_i) begin
                     state_next = (POST_TRIG == 0) ? FROZEN : POST;
                  end
         POST:    if (capture_valid_i && (post_cnt == AW'(1))) begin
                     state_next = FROZEN;
                  end
         FROZEN:  if (freeze_clr_i) begin
                     state_next = RUN;
                  end
         default: state_next = RUN;
      endcase
   end

   // A clear in FROZEN takes priority and drops any coincident capture.
   always_comb begin
      capture_en = capture_valid_i && (state != FROZEN);
      clear_en   = freeze_clr_i && (state == FROZEN);
      frozen_o   = (state == FROZEN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         post_cnt <= '0;
      end else if ((state == RUN) && capture_valid_i && illegal_insn_i) begin
         post_cnt <= POST_LOAD;
      end else if ((state == POST) && capture_valid_i) begin
         post_cnt <= post_cnt - AW'(1);
      end
   end
`else
   localparam int UNUSED_POST_TRIG = POST_TRIG;
   logic unused_freeze_clr;

   assign unused_freeze_clr = freeze_clr_i;
   assign capture_en        = capture_valid_i;
   assign clear_en          = 1'b0;
   assign frozen_o          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear_en) begin
         count <= '0;
      end else if (capture_en) begin
         wr_ptr <= wr_ptr + AW'(1);
         if (count != DEPTH_CNT) begin
            count <= count + (AW+1)'(1);
         end
      end
   end

   // DEPTH is a power of two, so AW-bit arithmetic wraps modulo DEPTH.
   assign rd_slot = wr_ptr - AW'(1) - rd_idx_i;
   assign rd_oob  = ({1'b0, rd_idx_i} >= count);
   assign count_o = count;

   cv32e40s_dbg_trace_mem #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk    (clk),
      .rst    (rst),
      .we     (capture_en),
      .waddr  (wr_ptr),
      .wdata  (wr_entry),
      .re     (rd_req_i),
      .raddr  (rd_slot),
      .rzero  (rd_oob),
      .rvalid (rd_valid_o),
      .rerr   (rd_err_o),
      .rdata  (rd_entry_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_cv32e40s_dbg_trace_buf.sv
`default_nettype none
// ============================================================================
// tb_cv32e40s_dbg_trace_buf : self-checking bench with a queue-based history
// model of the trace buffer.  Revision 1.0
// ============================================================================
module tb_cv32e40s_dbg_trace_buf;
   import cv32e40s_pkg::*;

   localparam int DEPTH     = 8;
   localparam int NRP       = 2;
   localparam int POST_TRIG = 2;
   localparam int AW        = 3;
`ifdef CV32E40S_DBG_TRACE_FREEZE_EN
   localparam bit FREEZE_EN = 1'b1;
`else
   localparam bit FREEZE_EN = 1'b0;
`endif
   localparam int M_RUN    = 0;
   localparam int M_POST   = 1;
   localparam int M_FROZEN = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             capture_valid_i = 1'b0;
   logic [31:0]      instr_i = '0;
   logic             is_compressed_i = 1'b0;
   logic [NRP-1:0]   rf_re_i = '0;
   rf_addr_t         rf_raddr_i [NRP];
   logic             rf_we_i = 1'b0;
   rf_addr_t         rf_waddr_i = '0;
   logic             illegal_insn_i = 1'b0;
   logic             freeze_clr_i = 1'b0;
   logic             rd_req_i = 1'b0;
   logic [AW-1:0]    rd_idx_i = '0;
   logic             rd_valid_o;
   logic             rd_err_o;
   dbg_trace_entry_t rd_entry_o;
   logic [AW:0]      count_o;
   logic             frozen_o;

   int n_checks = 0;
   int n_fail   = 0;

   dbg_trace_entry_t hist [$];
   int               mode;
   int               post_left;
   logic             exp_valid;
   logic             exp_err;
   dbg_trace_entry_t exp_entry;

   cv32e40s_dbg_trace_buf #(
      .DEPTH                  (DEPTH),
      .REGFILE_NUM_READ_PORTS (NRP),
      .POST_TRIG              (POST_TRIG)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .capture_valid_i (capture_valid_i),
      .instr_i         (instr_i),
      .is_compressed_i (is_compressed_i),
      .rf_re_i         (rf_re_i),
      .rf_raddr_i      (rf_raddr_i),
      .rf_we_i         (rf_we_i),
      .rf_waddr_i      (rf_waddr_i),
      .illegal_insn_i  (illegal_insn_i),
      .freeze_clr_i    (freeze_clr_i),
      .rd_req_i        (rd_req_i),
      .rd_idx_i        (rd_idx_i),
      .rd_valid_o      (rd_valid_o),
      .rd_err_o        (rd_err_o),
      .rd_entry_o      (rd_entry_o),
      .count_o         (count_o),
      .frozen_o        (frozen_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic dbg_trace_entry_t mk(input logic [31:0] ins, input logic ill);
      dbg_trace_entry_t e;
      e               = '0;
      e.instr         = ins;
      e.is_compressed = 1'($urandom_range(0, 1));
      e.rf_re         = NRP'($urandom_range(0, 3));
      e.rf_raddr[0]   = 5'($urandom_range(0, 31));
      e.rf_raddr[1]   = 5'($urandom_range(0, 31));
      e.rf_we         = 1'($urandom_range(0, 1));
      e.rf_waddr      = 5'($urandom_range(0, 31));
      e.illegal_insn  = ill;
      return e;
   endfunction

   task automatic model_reset();
      hist.delete();
      mode      = M_RUN;
      post_left = 0;
   endtask

   // History is a newest-first list, so age index equals queue position.
   task automatic model_step(input logic cv, input dbg_trace_entry_t e, input logic clr);
      if (mode == M_FROZEN) begin
         if (clr) begin
            mode = M_RUN;
            hist.delete();
         end
      end else if (cv) begin
         hist.push_front(e);
         if (hist.size() > DEPTH) void'(hist.pop_back());
         if (FREEZE_EN && mode == M_RUN && e.illegal_insn) begin
            if (POST_TRIG == 0) mode = M_FROZEN;
            else begin
               mode      = M_POST;
               post_left = POST_TRIG;
            end
         end else if (mode == M_POST) begin
            post_left--;
            if (post_left == 0) mode = M_FROZEN;
         end
      end
   endtask

   task automatic cycle(input logic cv, input dbg_trace_entry_t e, input logic clr,
                        input logic rq, input int idx);
      capture_valid_i = cv;
      instr_i         = e.instr;
      is_compressed_i = e.is_compressed;
      rf_re_i         = e.rf_re;
      for (int p = 0; p < NRP; p++) rf_raddr_i[p] = e.rf_raddr[p];
      rf_we_i         = e.rf_we;
      rf_waddr_i      = e.rf_waddr;
      illegal_insn_i  = e.illegal_insn;
      freeze_clr_i    = clr;
      rd_req_i        = rq;
      rd_idx_i        = AW'(idx);
      exp_valid       = rq;
      if (idx < hist.size()) begin
         exp_err   = 1'b0;
         exp_entry = hist[idx];
      end else begin
         exp_err   = 1'b1;
         exp_entry = '0;
      end
      @(posedge clk);
      #1;
      model_step(cv, e, clr);
      capture_valid_i = 1'b0;
      illegal_insn_i  = 1'b0;
      freeze_clr_i    = 1'b0;
      rd_req_i        = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      dbg_trace_entry_t z;
      z = '0;
      for (int p = 0; p < NRP; p++) rf_raddr_i[p] = '0;
      model_reset();
      #1;
      n_checks++;
      if (count_o !== '0) begin
         n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o);
      end
      n_checks++;
      if ({rd_valid_o, rd_err_o, frozen_o} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {rd_valid_o, rd_err_o, frozen_o});
      end
      n_checks++;
      if (rd_entry_o !== z) begin
         n_fail++; $display("FAIL reset_entry: got %h expected 0", rd_entry_o);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_basic_capture();
      logic [31:0] ins [3];
      ins[0] = 32'h0020_8113;
      ins[1] = 32'h0010_0093;
      ins[2] = 32'h0000_0013;
      apply_reset();
      cycle(1'b1, mk(32'h0000_0013, 1'b0), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(32'h0010_0093, 1'b0), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(32'h0020_8113, 1'b0), 1'b0, 1'b0, 0);
      n_checks++;
      if (count_o !== 4'd3) begin
         n_fail++; $display("FAIL basic_count: got %0d expected 3", count_o);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1, i);
         n_checks++;
         if (rd_valid_o !== 1'b1 || rd_err_o !== (i == 3) || rd_entry_o !== exp_entry) begin
            n_fail++;
            $display("FAIL basic_read idx%0d: got v=%b e=%b %h expected v=1 e=%b %h",
                     i, rd_valid_o, rd_err_o, rd_entry_o, (i == 3), exp_entry);
         end
         if (i < 3) begin
            n_checks++;
            if (rd_entry_o.instr !== ins[i]) begin
               n_fail++; $display("FAIL basic_instr idx%0d: got %h expected %h", i, rd_entry_o.instr, ins[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int k = 1; k <= 11; k++) cycle(1'b1, mk(32'h1000_0000 + k, 1'b0), 1'b0, 1'b0, 0);
      n_checks++;
      if (count_o !== 4'd8) begin
         n_fail++; $display("FAIL wrap_count: got %0d expected 8", count_o);
      end
      cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1, 7);
      n_checks++;
      if (rd_err_o !== 1'b0 || rd_entry_o.instr !== 32'h1000_0004 || rd_entry_o !== exp_entry) begin
         n_fail++; $display("FAIL wrap_idx7: got %h expected instr 10000004", rd_entry_o.instr);
      end
      cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1, 0);
      n_checks++;
      if (rd_err_o !== 1'b0 || rd_entry_o.instr !== 32'h1000_000B || rd_entry_o !== exp_entry) begin
         n_fail++; $display("FAIL wrap_idx0: got %h expected instr 1000000b", rd_entry_o.instr);
      end
   endtask

   task automatic test_trigger();
      apply_reset();
      cycle(1'b1, mk(32'h0000_0013, 1'b0), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(32'h0010_0093, 1'b0), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(32'h0000_0000, 1'b1), 1'b0, 1'b0, 0);
      n_checks++;
      if (frozen_o !== 1'b0) begin
         n_fail++; $display("FAIL trig_frozen_early: got %b expected 0", frozen_o);
      end
      for (int j = 1; j <= 4; j++) begin
         cycle(1'b1, mk(32'h2000_0000 + j, 1'b0), 1'b0, 1'b0, 0);
         n_checks++;
         if (frozen_o !== (FREEZE_EN && j >= 2)) begin
            n_fail++; $display("FAIL trig_frozen post%0d: got %b expected %b", j, frozen_o, (FREEZE_EN && j >= 2));
         end
      end
      n_checks++;
      if (count_o !== (FREEZE_EN ? 4'd5 : 4'd7)) begin
         n_fail++; $display("FAIL trig_count: got %0d expected %0d", count_o, (FREEZE_EN ? 5 : 7));
      end
      cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1, 2);
      n_checks++;
      if (rd_err_o !== 1'b0 || rd_entry_o !== exp_entry) begin
         n_fail++; $display("FAIL trig_idx2: got %h expected %h", rd_entry_o, exp_entry);
      end
   endtask

   task automatic test_freeze_clear();
      dbg_trace_entry_t e2;
      e2 = mk(32'h3000_0002, 1'b0);
      cycle(1'b1, mk(32'h3000_0001, 1'b0), 1'b1, 1'b0, 0);
      n_checks++;
      if (count_o !== (FREEZE_EN ? 4'd0 : 4'd8) || frozen_o !== 1'b0) begin
         n_fail++; $display("FAIL clr_count: got %0d/%b expected %0d/0", count_o, frozen_o, (FREEZE_EN ? 0 : 8));
      end
      cycle(1'b1, e2, 1'b0, 1'b0, 0);
      n_checks++;
      if (count_o !== (FREEZE_EN ? 4'd1 : 4'd8)) begin
         n_fail++; $display("FAIL clr_next_count: got %0d expected %0d", count_o, (FREEZE_EN ? 1 : 8));
      end
      cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1, 0);
      n_checks++;
      if (rd_err_o !== 1'b0 || rd_entry_o !== e2) begin
         n_fail++; $display("FAIL clr_read: got %h expected %h", rd_entry_o, e2);
      end
   endtask

   task automatic test_same_cycle_read();
      dbg_trace_entry_t a;
      dbg_trace_entry_t b;
      a = mk(32'h4000_000A, 1'b0);
      b = mk(32'h4000_000B, 1'b0);
      apply_reset();
      cycle(1'b1, a, 1'b0, 1'b0, 0);
      cycle(1'b1, b, 1'b0, 1'b1, 0);
      n_checks++;
      if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b0 || rd_entry_o !== a) begin
         n_fail++; $display("FAIL same_cycle_old: got %h expected %h", rd_entry_o, a);
      end
      cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b1, 0);
      n_checks++;
      if (rd_valid_o !== 1'b1 || rd_entry_o !== b) begin
         n_fail++; $display("FAIL same_cycle_new: got %h expected %h", rd_entry_o, b);
      end
      cycle(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0, 0);
      n_checks++;
      if (rd_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL valid_pulse: got %b expected 0", rd_valid_o);
      end
   endtask

   task automatic test_reset_mid_post();
      dbg_trace_entry_t z;
      z = '0;
      apply_reset();
      cycle(1'b1, mk(32'h0000_0000, 1'b1), 1'b0, 1'b0, 0);
      cycle(1'b1, mk(32'h5000_0001, 1'b0), 1'b0, 1'b1, 0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({rd_valid_o, rd_err_o, frozen_o} !== 3'b000 || count_o !== '0 || rd_entry_o !== z) begin
         n_fail++;
         $display("FAIL midpost_reset: got v=%b e=%b f=%b c=%0d d=%h expected all 0",
                  rd_valid_o, rd_err_o, frozen_o, count_o, rd_entry_o);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      cycle(1'b1, mk(32'h5000_0002, 1'b0), 1'b0, 1'b0, 0);
      n_checks++;
      if (frozen_o !== 1'b0 || count_o !== 4'd1) begin
         n_fail++; $display("FAIL midpost_run: got f=%b c=%0d expected f=0 c=1", frozen_o, count_o);
      end
   endtask

   task automatic test_random();
      logic cv, clr, rq, ill;
      int   idx;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         cv  = ($urandom_range(0, 3) != 0);
         ill = ($urandom_range(0, 15) == 0);
         clr = ($urandom_range(0, 7) == 0);
         rq  = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, DEPTH - 1);
         cycle(cv, mk($urandom(), ill), clr, rq, idx);
         n_checks++;
         if (rd_valid_o !== exp_valid) begin
            n_fail++; $display("FAIL rand_valid cyc%0d: got %b expected %b", n, rd_valid_o, exp_valid);
         end
         if (exp_valid) begin
            n_checks++;
            if (rd_err_o !== exp_err || rd_entry_o !== exp_entry) begin
               n_fail++;
               $display("FAIL rand_read cyc%0d idx%0d: got e=%b %h expected e=%b %h",
                        n, idx, rd_err_o, rd_entry_o, exp_err, exp_entry);
            end
         end
         n_checks++;
         if (count_o !== (AW+1)'(hist.size()) || frozen_o !== (mode == M_FROZEN)) begin
            n_fail++;
            $display("FAIL rand_state cyc%0d: got c=%0d f=%b expected c=%0d f=%b",
                     n, count_o, frozen_o, hist.size(), (mode == M_FROZEN));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_wrap();
      test_trigger();
      test_freeze_clear();
      test_same_cycle_read();
      test_reset_mid_post();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
